// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one registered adder among NUM_REQ requesters.
// Optional per-requester grant counters: define ADDER_RR_SCHED_STATS_EN.
module adder_rr_sched #(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = 4,
   parameter  int ADD_LAT = 1,
   localparam int RES_W   = DATA_W + 1,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         add_a,
   output logic [DATA_W-1:0]         add_b,
   output logic                      add_valid,
   input  logic [RES_W-1:0]          add_c,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [RES_W-1:0]          rsp_c,
   output logic                      idle
`ifdef ADDER_RR_SCHED_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

   typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} state_t;

   state_t                     state_q, state_d;
   logic [ID_W-1:0]            ptr_q, ptr_d;
   logic [DATA_W-1:0]          add_a_q, add_a_d;
   logic [DATA_W-1:0]          add_b_q, add_b_d;
   logic [ADD_LAT:0]           vld_pipe_q, vld_pipe_d;
   logic [ADD_LAT:0][ID_W-1:0] id_pipe_q, id_pipe_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]            rsp_id_q, rsp_id_d;
   logic [RES_W-1:0]           rsp_c_q, rsp_c_d;
   logic                       idle_q, idle_d;

   logic [NUM_REQ-1:0]         gnt;
   logic [ID_W-1:0]            gnt_id;
   logic                       xfer;
   logic                       in_flight;

   // Rotating priority: scan from ptr+1 upward, wrapping, first valid wins.
   always_comb begin
      int idx;
      gnt    = '0;
      gnt_id = '0;
      xfer   = 1'b0;
      idx    = 0;
      if (state_q == ST_RUN) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!xfer && req_valid[idx]) begin
               xfer     = 1'b1;
               gnt[idx] = 1'b1;
               gnt_id   = ID_W'(idx);
            end
         end
      end
   end

   assign req_ready = gnt;
   assign in_flight = (|vld_pipe_q) || rsp_valid_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_STOP:  if (enable) state_d = ST_RUN;
         ST_RUN:   if (!enable) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (enable)          state_d = ST_RUN;
            else if (!in_flight) state_d = ST_STOP;
         end
         default:  state_d = ST_STOP;
      endcase

      ptr_d   = xfer ? gnt_id : ptr_q;
      add_a_d = xfer ? req_a[gnt_id*DATA_W +: DATA_W] : add_a_q;
      add_b_d = xfer ? req_b[gnt_id*DATA_W +: DATA_W] : add_b_q;

      // Stage j holds the op whose adder cycle was j cycles ago; stage 0 is add_valid.
      vld_pipe_d   = {vld_pipe_q[ADD_LAT-1:0], xfer};
      id_pipe_d[0] = gnt_id;
      for (int k = 1; k <= ADD_LAT; k++) id_pipe_d[k] = id_pipe_q[k-1];

      rsp_valid_d = vld_pipe_q[ADD_LAT];
      rsp_id_d    = vld_pipe_q[ADD_LAT] ? id_pipe_q[ADD_LAT] : rsp_id_q;
      rsp_c_d     = vld_pipe_q[ADD_LAT] ? add_c : rsp_c_q;

      idle_d = (state_q == ST_STOP) && !in_flight;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_STOP;
         ptr_q       <= ID_W'(NUM_REQ - 1);
         add_a_q     <= '0;
         add_b_q     <= '0;
         vld_pipe_q  <= '0;
         id_pipe_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_c_q     <= '0;
         idle_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         vld_pipe_q  <= vld_pipe_d;
         id_pipe_q   <= id_pipe_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_c_q     <= rsp_c_d;
         idle_q      <= idle_d;
      end
   end

   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign add_valid = vld_pipe_q[0];
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_c     = rsp_c_q;
   assign idle      = idle_q;

`ifdef ADDER_RR_SCHED_STATS_EN
   logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;

   // Saturating per-requester transfer counters.
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i] && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_adder_rr_sched.sv
// Randomized bench for adder_rr_sched: rotation/latency scoreboard plus a behavioural adder.
module tb_adder_rr_sched;
   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 4;
   localparam int ADD_LAT = 1;
   localparam int RES_W   = DATA_W + 1;
   localparam int ID_W    = $clog2(NUM_REQ);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      reset, enable;
   logic [NUM_REQ-1:0]        rv;
   logic [NUM_REQ*DATA_W-1:0] req_a, req_b;
   logic [NUM_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]         add_a, add_b;
   logic                      add_valid;
   logic [RES_W-1:0]          add_c;
   logic                      rsp_valid;
   logic [ID_W-1:0]           rsp_id;
   logic [RES_W-1:0]          rsp_c;
   logic                      idle;
`ifdef ADDER_RR_SCHED_STATS_EN
   logic [NUM_REQ*16-1:0]     grant_cnt;
`endif

   logic [DATA_W-1:0] ra [NUM_REQ];
   logic [DATA_W-1:0] rb [NUM_REQ];

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_a[i*DATA_W +: DATA_W] = ra[i];
         req_b[i*DATA_W +: DATA_W] = rb[i];
      end
   end

   adder_rr_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADD_LAT(ADD_LAT)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .req_valid(rv), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .add_a(add_a), .add_b(add_b), .add_valid(add_valid), .add_c(add_c),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_c(rsp_c), .idle(idle)
`ifdef ADDER_RR_SCHED_STATS_EN
      , .grant_cnt(grant_cnt)
`endif
   );

   // Behavioural adder: c appears ADD_LAT cycles after a/b are sampled.
   logic [RES_W-1:0] apipe [ADD_LAT];
   always @(posedge clk) begin
      apipe[0] <= RES_W'(add_a) + RES_W'(add_b);
      for (int k = 1; k < ADD_LAT; k++) apipe[k] <= apipe[k-1];
   end
   assign add_c = apipe[ADD_LAT-1];

   typedef struct {int due; int id; int c;} exp_t;
   exp_t q[$];

   int n_cmp = 0, n_bad = 0, cyc = 0;
   int mptr, exp_a, exp_b, last_w, pct;
   bit prev_en, exp_av, fixed_ops;
   logic [NUM_REQ-1:0] want;
   logic [DATA_W-1:0] fa [NUM_REQ];
   logic [DATA_W-1:0] fb [NUM_REQ];
   int gcount [NUM_REQ];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic clear_model();
      q.delete();
      mptr = NUM_REQ - 1; exp_av = 0; exp_a = 0; exp_b = 0; prev_en = 0; last_w = -1;
      for (int i = 0; i < NUM_REQ; i++) gcount[i] = 0;
   endtask

   // Negedge: registered outputs reflect the previous rising edge.
   task automatic check_phase();
      @(negedge clk);
      cyc++;
      chk("add_valid", add_valid, exp_av);
      chk("add_a", add_a, exp_a);
      chk("add_b", add_b, exp_b);
      if (q.size() > 0 && q[0].due == cyc) begin
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_id", rsp_id, q[0].id);
         chk("rsp_c", rsp_c, q[0].c);
         void'(q.pop_front());
      end else begin
         chk("rsp_valid", rsp_valid, 0);
      end
      if (last_w >= 0) rv[last_w] = 1'b0;
      last_w = -1;
   endtask

   // After inputs settle: predict the grant for the coming edge and advance the model.
   task automatic arb_phase();
      logic [NUM_REQ-1:0] eg;
      int w, idx;
      #1;
      eg = '0; w = -1;
      if (prev_en) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (mptr + k) % NUM_REQ;
            if (w < 0 && rv[idx]) begin w = idx; eg[idx] = 1'b1; end
         end
      end
      chk("req_ready", req_ready, eg);
      if (reset) begin
         clear_model();
      end else begin
         if (w >= 0) begin
            mptr = w;
            q.push_back('{cyc + ADD_LAT + 2, w, int'(ra[w]) + int'(rb[w])});
            exp_av = 1; exp_a = ra[w]; exp_b = rb[w];
            gcount[w]++;
            last_w = w;
         end else begin
            exp_av = 0;
         end
         prev_en = enable;
      end
   endtask

   task automatic drive_auto();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!rv[i] && want[i] && $urandom_range(99) < pct) begin
            rv[i] = 1'b1;
            ra[i] = fixed_ops ? fa[i] : DATA_W'($urandom);
            rb[i] = fixed_ops ? fb[i] : DATA_W'($urandom);
         end
      end
   endtask

   task automatic step();
      check_phase(); drive_auto(); arb_phase();
   endtask

   task automatic do_reset();
      check_phase();
      reset = 1'b1; enable = 1'b0; rv = '0;
      arb_phase();
      check_phase();
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_c", rsp_c, 0);
      chk("rst_idle", idle, 1);
      reset = 1'b0;
      arb_phase();
   endtask

   task automatic start_run();
      check_phase(); enable = 1'b1; arb_phase();
   endtask

   task automatic drain(input string tag);
      for (int t = 0; t < 30 && q.size() > 0; t++) step();
      chk(tag, q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; rv = '0; want = '0; pct = 100; fixed_ops = 0;
      for (int i = 0; i < NUM_REQ; i++) begin ra[i] = '0; rb[i] = '0; fa[i] = '0; fb[i] = '0; end
      clear_model();
      repeat (3) @(negedge clk);
      chk("init_add_valid", add_valid, 0);
      chk("init_add_a", add_a, 0);
      chk("init_rsp_valid", rsp_valid, 0);
      chk("init_rsp_id", rsp_id, 0);
      chk("init_rsp_c", rsp_c, 0);
      chk("init_idle", idle, 1);
      reset = 1'b0;
      arb_phase();

      // Single transfer 3+5 from requester 0.
      start_run();
      check_phase(); rv[0] = 1'b1; ra[0] = 4'd3; rb[0] = 4'd5; arb_phase();
      repeat (5) step();
      chk("run_idle", idle, 0);

      // Full load with a=i, b=15: strict rotation from requester 0.
      do_reset();
      start_run();
      want = '1; pct = 100; fixed_ops = 1;
      for (int i = 0; i < NUM_REQ; i++) begin fa[i] = DATA_W'(i); fb[i] = 4'd15; end
      repeat (12) step();
      want = '0;
      drain("rot_drain");

      // Requester 2 alone, 15+15, five consecutive grants.
      want = 4'b0100; fa[2] = 4'd15; fb[2] = 4'd15;
      repeat (5) step();
      want = '0;
      drain("single_drain");

      // Full load, enable drops with the second grant; pending results drain, then idle.
      do_reset();
      start_run();
      want = '1; fixed_ops = 0;
      step();
      check_phase(); enable = 1'b0; drive_auto(); arb_phase();
      want = '0;
      drain("stop_drain");
      step(); step();
      chk("idle_before_stop", idle, 0);
      step();
      chk("idle_after_stop", idle, 1);

      // Reset one cycle after a grant discards the in-flight op.
      do_reset();
      start_run();
      want = '1;
      step();
      do_reset();
      start_run();
      repeat (8) step();
      want = '0;
      drain("rst_drain");

      // Randomized traffic with enable toggling and occasional reset.
      start_run();
      for (int n = 0; n < 400; n++) begin
         if (n % 25 == 0) begin pct = $urandom_range(100); want = NUM_REQ'($urandom); end
         check_phase();
         if ($urandom_range(99) == 0) begin
            reset = 1'b1; enable = 1'b0; rv = '0;
         end else begin
            reset = 1'b0;
            if ($urandom_range(9) == 0) enable = ~enable;
            drive_auto();
         end
         arb_phase();
      end
      check_phase(); reset = 1'b0; want = '0; arb_phase();
      drain("rand_drain");

`ifdef ADDER_RR_SCHED_STATS_EN
      do_reset();
      start_run();
      want = 4'b0010; pct = 100;
      repeat (3) step();
      want = 4'b1000;
      step();
      want = '0;
      drain("stats_drain");
      for (int i = 0; i < NUM_REQ; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], gcount[i]);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
